// File: rtl/snn_frame_ctrl_if.sv
// Bundle of UART, input-RAM, SNN-core and status signals
// around the frame controller.
interface snn_frame_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_d;
    logic [ADDR_W-1:0] core_addr;
    logic              core_start;
    logic              core_done;
    logic [3:0]        core_digit;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_rdy;
    logic [3:0]        result;
    logic              busy;
    logic              overrun;

    modport master (
        input  rx_rdy, rx_data, core_addr, core_done, core_digit, tx_rdy,
        output ram_we, ram_addr, ram_d, core_start, tx_start, tx_data,
        output result, busy, overrun
    );

    modport slave (
        output rx_rdy, rx_data, core_addr, core_done, core_digit, tx_rdy,
        input  ram_we, ram_addr, ram_d, core_start, tx_start, tx_data,
        input  result, busy, overrun
    );
endinterface

// File: rtl/snn_frame_ctrl.sv
// Frame sequencer: unpacks received bytes into pixel writes, runs the
// SNN core with a timeout and sends one result byte per frame.
module snn_frame_ctrl #(
    parameter int          NUM_BYTES    = 98,
    parameter int          ADDR_W       = 10,
    parameter logic [19:0] CORE_TIMEOUT = 20'd1000000,
    parameter logic [7:0]  ERR_BYTE     = 8'hFF
) (
    input logic              clk,
    input logic              rst_n,
    snn_frame_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        START,
        CORE,
        TX_REQ,
        TX_WAIT
    } state_t;

    state_t            state, state_d;
    logic [6:0]        byte_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic [7:0]        pend;
    logic              pend_vld;
    logic [19:0]       timer;
    logic [7:0]        tx_data;
    logic [3:0]        result;
    logic              overrun;
    logic              seen_low;

    logic              ram_we;
    logic              ram_d;
    logic              core_start;
    logic              tx_start;
    logic [ADDR_W-1:0] ram_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              last_byte;
    logic              timeout;
    logic              pend_in;
    logic              drop;

    assign wr_addr   = ADDR_W'({byte_cnt, bit_cnt});
    assign last_byte = byte_cnt == 7'(NUM_BYTES - 1);
    assign timeout   = timer == CORE_TIMEOUT - 20'd1;
    assign pend_in   = bus.rx_rdy && state == UNPACK && !pend_vld;
    // A byte is lost when the buffer is full or the frame is being classified.
    assign drop      = bus.rx_rdy &&
                       (pend_vld || !(state == IDLE || state == UNPACK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        ram_we     = 1'b0;
        ram_d      = 1'b0;
        ram_addr   = '0;
        core_start = 1'b0;
        tx_start   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend_vld || bus.rx_rdy) state_d = UNPACK;
            end
            UNPACK: begin
                ram_we   = 1'b1;
                ram_addr = wr_addr;
                ram_d    = shift[bit_cnt];
                if (bit_cnt == 3'd7) state_d = last_byte ? START : IDLE;
            end
            START: begin
                ram_addr   = wr_addr;
                core_start = 1'b1;
                state_d    = CORE;
            end
            CORE: begin
                ram_addr = bus.core_addr;
                if (bus.core_done || timeout) state_d = TX_REQ;
            end
            TX_REQ: begin
                ram_addr = wr_addr;
                if (bus.tx_rdy) begin
                    tx_start = 1'b1;
                    state_d  = TX_WAIT;
                end
            end
            TX_WAIT: begin
                ram_addr = wr_addr;
                if (bus.tx_rdy && seen_low) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            timer    <= '0;
            tx_data  <= '0;
            result   <= '0;
            overrun  <= 1'b0;
            seen_low <= 1'b0;
        end else begin
            overrun <= overrun | drop;
            if (pend_in) begin
                pend     <= bus.rx_data;
                pend_vld <= 1'b1;
            end else if (state == IDLE) begin
                pend_vld <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (pend_vld) shift <= pend;
                    else if (bus.rx_rdy) shift <= bus.rx_data;
                end
                UNPACK: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 7'd1;
                end
                START: begin
                    timer <= '0;
                end
                CORE: begin
                    timer <= timer + 20'd1;
                    if (bus.core_done) begin
                        result  <= bus.core_digit;
                        tx_data <= {4'h0, bus.core_digit};
                    end else if (timeout) begin
                        tx_data <= ERR_BYTE;
                    end
                end
                TX_REQ: begin
                    seen_low <= 1'b0;
                end
                TX_WAIT: begin
                    if (!bus.tx_rdy) seen_low <= 1'b1;
                    else if (seen_low) byte_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_we     = ram_we;
    assign bus.ram_addr   = ram_addr;
    assign bus.ram_d      = ram_d;
    assign bus.core_start = core_start;
    assign bus.tx_start   = tx_start;
    assign bus.tx_data    = tx_data;
    assign bus.result     = result;
    assign bus.busy       = state != IDLE;
    assign bus.overrun    = overrun;

endmodule
